// File: rtl/inst_queue_if.sv
// Fetch/decode side bundle of the instruction queue: cache-return push
// bundle, decode pop request, and the queue's status/output slots.
interface inst_queue_if #(
  parameter int DEPTH = 16,
  parameter int PW    = $clog2(DEPTH)
);
  logic          flush;
  logic          in_valid;
  logic [255:0]  in_data;
  logic [3:0]    in_num;
  logic [31:0]   in_pc;
  logic          space_ok;
  logic [1:0]    out_count;
  logic [31:0]   out_inst0;
  logic [31:0]   out_pc0;
  logic [31:0]   out_inst1;
  logic [31:0]   out_pc1;
  logic [1:0]    pop_num;
  logic [PW:0]   count;
  logic          overflow;

  // Fetch/decode side: drives pushes, pops and flush
  modport master (
    output flush, in_valid, in_data, in_num, in_pc, pop_num,
    input  space_ok, out_count, out_inst0, out_pc0, out_inst1, out_pc1,
           count, overflow
  );

  // Queue side
  modport slave (
    input  flush, in_valid, in_data, in_num, in_pc, pop_num,
    output space_ok, out_count, out_inst0, out_pc0, out_inst1, out_pc1,
           count, overflow
  );
endinterface

// File: rtl/inst_queue.sv
// Instruction queue between icache and dual-issue decode. Accepts up to 8
// instructions per cycle into a circular buffer, tags each with its PC and
// presents the two oldest entries. Oversized pushes are truncated to the free
// space and flagged through a sticky overflow bit.
module inst_queue #(
  parameter int DEPTH = 16,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         resetn,
  inst_queue_if.slave  q
);
  localparam int CW = PW + 1;

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;

  // Entry storage; contents are never reset, only pointers are
  logic [31:0] inst_mem [DEPTH];
  logic [31:0] pc_mem   [DEPTH];

  logic [3:0]    n_raw;
  logic [CW-1:0] free_space;
  logic [CW-1:0] n_in;
  logic          ovf_hit;
  logic [1:0]    occ2;
  logic [1:0]    pop_req;
  logic [1:0]    n_out;
  logic [PW-1:0] head1;

  // Per-entry write decode: each entry picks its slot by distance from tail
  logic [PW-1:0] wr_off  [DEPTH];
  logic          wr_en   [DEPTH];
  logic [31:0]   wr_inst [DEPTH];
  logic [31:0]   wr_pc   [DEPTH];

  assign free_space = CW'(DEPTH) - count_q;
  assign occ2       = (count_q >= CW'(2)) ? 2'd2 : count_q[1:0];
  assign pop_req    = (q.pop_num == 2'd3) ? 2'd2 : q.pop_num;
  assign n_out      = (pop_req > occ2) ? occ2 : pop_req;

  // Clamp the push to 8 slots and then to the pre-pop free space
  always_comb begin
    n_raw   = 4'd0;
    n_in    = '0;
    ovf_hit = 1'b0;
    if (q.in_valid && q.in_num != 4'd0)
      n_raw = (q.in_num > 4'd8) ? 4'd8 : q.in_num;
    if (CW'(n_raw) > free_space) begin
      n_in    = free_space;
      ovf_hit = 1'b1;
    end else begin
      n_in = CW'(n_raw);
    end
  end

  // Next-state for pointers, occupancy and the sticky overflow flag
  always_comb begin
    head_d     = head_q + PW'(n_out);
    tail_d     = tail_q + n_in[PW-1:0];
    count_d    = count_q + n_in - CW'(n_out);
    overflow_d = overflow_q | ovf_hit;
    if (q.flush) begin
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      overflow_d = overflow_q;
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr
      assign wr_off[gi]  = PW'(gi) - tail_q;
      assign wr_en[gi]   = !q.flush && ({1'b0, wr_off[gi]} < n_in);
      assign wr_inst[gi] = q.in_data[{wr_off[gi][2:0], 5'b00000} +: 32];
      assign wr_pc[gi]   = q.in_pc + {27'd0, wr_off[gi][2:0], 2'b00};
    end
  endgenerate

  // Pointer/count state with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!resetn) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Multi-entry write of the pushed bundle, including wrap past DEPTH-1
  always_ff @(posedge clk) begin
    for (int e = 0; e < DEPTH; e++) begin
      if (wr_en[e]) begin
        inst_mem[e] <= wr_inst[e];
        pc_mem[e]   <= wr_pc[e];
      end
    end
  end

  assign head1       = head_q + PW'(1);
  assign q.space_ok  = free_space >= CW'(8);
  assign q.out_count = occ2;
  assign q.out_inst0 = inst_mem[head_q];
  assign q.out_pc0   = pc_mem[head_q];
  assign q.out_inst1 = inst_mem[head1];
  assign q.out_pc1   = pc_mem[head1];
  assign q.count     = count_q;
  assign q.overflow  = overflow_q;
endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue (DEPTH=16): push/pop, wrap, overflow, flush.
module tb_inst_queue;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  inst_queue_if #(.DEPTH(16)) bus ();

  inst_queue #(.DEPTH(16)) dut (
    .clk    (clk),
    .resetn (resetn),
    .q      (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs/outputs are handled 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_num   = 4'd0;
    bus.pop_num  = 2'd0;
  endtask

  task automatic set_push(input logic [3:0] num, input logic [31:0] pc, input logic [31:0] base);
    bus.in_valid = 1'b1;
    bus.in_num   = num;
    bus.in_pc    = pc;
    for (int k = 0; k < 8; k++) bus.in_data[32*k +: 32] = base + 32'(k);
  endtask

  task automatic show(input string name);
    $display("step %-14s count=%0d out_count=%0d inst0=%h pc0=%h inst1=%h pc1=%h space_ok=%0b ovf=%0b",
             name, bus.count, bus.out_count, bus.out_inst0, bus.out_pc0,
             bus.out_inst1, bus.out_pc1, bus.space_ok, bus.overflow);
  endtask

  initial begin
    idle();
    bus.in_pc   = 32'd0;
    bus.in_data = '0;
    // Reset
    resetn = 1'b0;
    tick(); tick();
    resetn = 1'b1;
    show("reset");
    chk("rst_count", 64'(bus.count), 64'd0);
    chk("rst_outcnt", 64'(bus.out_count), 64'd0);
    chk("rst_space", 64'(bus.space_ok), 64'd1);
    chk("rst_ovf", 64'(bus.overflow), 64'd0);

    // Push 8 from 0xBFC00000
    set_push(4'd8, 32'hBFC0_0000, 32'h1000_0000);
    tick(); idle(); show("push8");
    chk("p8_count", 64'(bus.count), 64'd8);
    chk("p8_outcnt", 64'(bus.out_count), 64'd2);
    chk("p8_inst0", 64'(bus.out_inst0), 64'h1000_0000);
    chk("p8_pc0", 64'(bus.out_pc0), 64'hBFC0_0000);
    chk("p8_inst1", 64'(bus.out_inst1), 64'h1000_0001);
    chk("p8_pc1", 64'(bus.out_pc1), 64'hBFC0_0004);
    chk("p8_space", 64'(bus.space_ok), 64'd1);

    // Push 3 at 0x100 while popping 2 -> count 9, head 2
    set_push(4'd3, 32'h0000_0100, 32'h2000_0000);
    bus.pop_num = 2'd2;
    tick(); idle(); show("push3pop2");
    chk("pp_count", 64'(bus.count), 64'd9);
    chk("pp_inst0", 64'(bus.out_inst0), 64'h1000_0002);
    chk("pp_pc0", 64'(bus.out_pc0), 64'hBFC0_0008);
    chk("pp_space", 64'(bus.space_ok), 64'd0);

    // Drain 6 old entries (pop_num=3 behaves as 2)
    bus.pop_num = 2'd3;
    tick(); tick(); tick(); idle(); show("drain_old");
    chk("dr_count", 64'(bus.count), 64'd3);
    chk("dr_inst0", 64'(bus.out_inst0), 64'h2000_0000);
    chk("dr_pc0", 64'(bus.out_pc0), 64'h0000_0100);
    chk("dr_inst1", 64'(bus.out_inst1), 64'h2000_0001);
    chk("dr_pc1", 64'(bus.out_pc1), 64'h0000_0104);
    bus.pop_num = 2'd2;
    tick(); idle(); show("pop2");
    chk("last_count", 64'(bus.count), 64'd1);
    chk("last_outcnt", 64'(bus.out_count), 64'd1);
    chk("last_inst0", 64'(bus.out_inst0), 64'h2000_0002);
    chk("last_pc0", 64'(bus.out_pc0), 64'h0000_0108);

    // pop_num=2 with one entry -> empty, head=tail=11
    bus.pop_num = 2'd2;
    tick(); idle(); show("pop_short");
    chk("ps_count", 64'(bus.count), 64'd0);
    chk("ps_outcnt", 64'(bus.out_count), 64'd0);

    // in_valid with in_num=0 is not a push; pop on empty is ignored
    set_push(4'd0, 32'h0000_0F00, 32'hDEAD_0000);
    bus.pop_num = 2'd2;
    tick(); idle(); show("num0");
    chk("n0_count", 64'(bus.count), 64'd0);

    // Move pointers to 14: push 3 then drain
    set_push(4'd3, 32'h0000_0200, 32'h3000_0000);
    tick(); idle();
    chk("adv_count", 64'(bus.count), 64'd3);
    chk("adv_inst0", 64'(bus.out_inst0), 64'h3000_0000);
    bus.pop_num = 2'd2;
    tick(); tick(); idle(); show("advance");
    chk("adv_empty", 64'(bus.count), 64'd0);

    // Wrapping push: entries 14,15,0,1,2
    set_push(4'd5, 32'h0000_0300, 32'h4000_0000);
    tick(); idle(); show("wrap_push");
    chk("wr_count", 64'(bus.count), 64'd5);
    chk("wr_inst0", 64'(bus.out_inst0), 64'h4000_0000);
    chk("wr_inst1", 64'(bus.out_inst1), 64'h4000_0001);
    bus.pop_num = 2'd1;
    tick(); idle(); show("wrap_pop1");
    chk("wp_count", 64'(bus.count), 64'd4);
    chk("wp_inst0", 64'(bus.out_inst0), 64'h4000_0001);
    chk("wp_pc0", 64'(bus.out_pc0), 64'h0000_0304);
    chk("wp_inst1", 64'(bus.out_inst1), 64'h4000_0002);
    chk("wp_pc1", 64'(bus.out_pc1), 64'h0000_0308);

    // Fill to 12, then overflow with 8 (only 4 land)
    set_push(4'd8, 32'h0000_0400, 32'h5000_0000);
    tick(); idle(); show("fill12");
    chk("f12_count", 64'(bus.count), 64'd12);
    chk("f12_space", 64'(bus.space_ok), 64'd0);
    chk("f12_ovf", 64'(bus.overflow), 64'd0);
    set_push(4'd8, 32'h0000_0500, 32'h6000_0000);
    tick(); idle(); show("overflow");
    chk("of_count", 64'(bus.count), 64'd16);
    chk("of_ovf", 64'(bus.overflow), 64'd1);
    chk("of_space", 64'(bus.space_ok), 64'd0);
    chk("of_outcnt", 64'(bus.out_count), 64'd2);

    // Push while full plus pop: free space from pre-pop count is 0
    set_push(4'd1, 32'h0000_0700, 32'h7700_0000);
    bus.pop_num = 2'd2;
    tick(); idle(); show("full_pushpop");
    chk("fp_count", 64'(bus.count), 64'd14);

    // Pop to the truncated burst and check its 4 entries
    bus.pop_num = 2'd2;
    tick(); tick(); tick(); tick(); tick(); idle(); show("to_trunc");
    chk("tr_count", 64'(bus.count), 64'd4);
    chk("tr_inst0", 64'(bus.out_inst0), 64'h6000_0000);
    chk("tr_pc0", 64'(bus.out_pc0), 64'h0000_0500);
    chk("tr_inst1", 64'(bus.out_inst1), 64'h6000_0001);
    bus.pop_num = 2'd2;
    tick(); idle(); show("trunc_tail");
    chk("tt_count", 64'(bus.count), 64'd2);
    chk("tt_inst0", 64'(bus.out_inst0), 64'h6000_0002);
    chk("tt_pc1", 64'(bus.out_pc1), 64'h0000_050C);

    // Flush with simultaneous push and pop
    set_push(4'd4, 32'h0000_0800, 32'h8000_0000);
    bus.pop_num = 2'd2;
    bus.flush   = 1'b1;
    tick(); idle(); show("flush");
    chk("fl_count", 64'(bus.count), 64'd0);
    chk("fl_outcnt", 64'(bus.out_count), 64'd0);
    chk("fl_space", 64'(bus.space_ok), 64'd1);
    chk("fl_ovf", 64'(bus.overflow), 64'd1);

    // After flush head is 0; in_num>8 clamps to 8
    set_push(4'd15, 32'hFFFF_FFFC, 32'h9000_0000);
    tick(); idle(); show("clamp_wrap_pc");
    chk("cl_count", 64'(bus.count), 64'd8);
    chk("cl_inst0", 64'(bus.out_inst0), 64'h9000_0000);
    chk("cl_pc0", 64'(bus.out_pc0), 64'hFFFF_FFFC);
    chk("cl_pc1", 64'(bus.out_pc1), 64'h0000_0000);

    // Reset mid-operation clears occupancy and overflow
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    show("reset2");
    chk("r2_count", 64'(bus.count), 64'd0);
    chk("r2_ovf", 64'(bus.overflow), 64'd0);
    chk("r2_space", 64'(bus.space_ok), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
